pdecoder_acc: RTL and testbench

//  Inverse of the priority encoder pencoder: turns a stream of binary indices into a WIDTH-bit
//  one-hot bitmap. Each accepted index sets or clears one bit of an accumulating mask. When a

---
 rtl/pdecoder_acc_pkg.sv | 24 ++
 rtl/pdecoder_acc_if.sv | 38 +++
 rtl/pdecoder_acc_pdecoder.sv | 30 +++
 rtl/pdecoder_acc.sv | 115 +++++++++++
 tb/tb_pdecoder_acc.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/pdecoder_acc_pkg.sv
// pdecoder_acc_pkg
//   Shared definitions for the index-to-bitmap accumulator:
//   - DEF_WIDTH  : default bitmap width
//   - idx_width(): index width for a given bitmap width (never below 1)
//   - state_e    : accumulator FSM states
package pdecoder_acc_pkg;

  localparam int DEF_WIDTH = 127;

  // Index width needed to address every bit of a WIDTH-bit bitmap.
  function automatic int idx_width(input int width);
    if (width > 1) begin
      return $clog2(width);
    end else begin
      return 1;
    end
  endfunction

  typedef enum logic {
    ACCUM = 1'b0,   // collecting index beats into the mask
    HOLD  = 1'b1    // snapshot pending on the output side
  } state_e;

endpackage

// File: rtl/pdecoder_acc_if.sv
// pdecoder_acc_if
//   Bundles the index input stream, the snapshot output stream, flush and
//   status signals of pdecoder_acc.
//   slave  : the accumulator itself
//   master : the producer/consumer environment driving it
//   Signals: flush, in_valid/in_ready/in_idx/in_set/in_last,
//            mask, out_valid/out_ready/out_mask, err
interface pdecoder_acc_if
  import pdecoder_acc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  localparam int IDXW = idx_width(WIDTH);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [IDXW-1:0]  in_idx;
  logic             in_set;
  logic             in_last;
  logic [WIDTH-1:0] mask;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_mask;
  logic             err;

  modport slave (
    input  flush, in_valid, in_idx, in_set, in_last, out_ready,
    output in_ready, mask, out_valid, out_mask, err
  );

  modport master (
    output flush, in_valid, in_idx, in_set, in_last, out_ready,
    input  in_ready, mask, out_valid, out_mask, err
  );

endinterface

// File: rtl/pdecoder_acc_pdecoder.sv
// pdecoder
//   Combinational binary-index to one-hot decoder (mirror of pencoder).
//   a : index, IDXW bits
//   o : one-hot bitmap, WIDTH bits; all zero when a is out of range
//   v : 1 when a < WIDTH
module pdecoder
  import pdecoder_acc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [idx_width(WIDTH)-1:0] a,
  output logic [WIDTH-1:0]            o,
  output logic                        v
);

  localparam int IDXW = idx_width(WIDTH);
  // One extra bit so WIDTH itself is representable even when WIDTH == 2**IDXW.
  localparam logic [IDXW:0] WIDTH_L = (IDXW+1)'(WIDTH);

  assign v = ({1'b0, a} < WIDTH_L);

  // Decode: bit i is set only for an in-range index equal to i.
  always_comb begin
    o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      o[i] = v && (a == IDXW'(i));
    end
  end

endmodule

// File: rtl/pdecoder_acc.sv
// pdecoder_acc
//   Accumulates a WIDTH-bit bitmap from a stream of (index, set/clear) beats.
//   A beat flagged last closes the frame: the updated mask is captured into
//   out_mask and offered on a valid/ready output, and the working mask
//   restarts from zero. While a snapshot is pending no beats are accepted.
//   Ports:
//     clk : clock, all state on posedge
//     rst : synchronous active-high reset
//     bus : pdecoder_acc_if slave modport (streams, flush, mask, err)
module pdecoder_acc
  import pdecoder_acc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  pdecoder_acc_if.slave  bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] out_mask_q, out_mask_d;
  logic             out_valid_q, out_valid_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] oh_s;
  logic             in_range_s;
  logic             in_ready_s;
  logic             accept_s;
  logic [WIDTH-1:0] mask_upd_s;

  pdecoder #(.WIDTH(WIDTH)) u_dec (
    .a (bus.in_idx),
    .o (oh_s),
    .v (in_range_s)
  );

  // flush blocks acceptance so a flushed cycle never also loads a beat.
  assign in_ready_s = (state_q == ACCUM) && !bus.flush;
  assign accept_s   = bus.in_valid && in_ready_s;

  // Out-of-range indices decode to zero, so set/clear leave the mask untouched.
  assign mask_upd_s = bus.in_set ? (mask_q | oh_s) : (mask_q & ~oh_s);

  // Next-state, mask, snapshot and error logic.
  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    out_mask_d  = out_mask_q;
    out_valid_d = out_valid_q;
    err_d       = err_q;
    case (state_q)
      ACCUM: begin
        if (bus.flush) begin
          mask_d = '0;
        end else if (accept_s) begin
          err_d = err_q | !in_range_s;
          if (bus.in_last) begin
            out_mask_d  = mask_upd_s;
            mask_d      = '0;
            out_valid_d = 1'b1;
            state_d     = HOLD;
          end else begin
            mask_d = mask_upd_s;
          end
        end else begin
          mask_d = mask_q;
        end
      end
      HOLD: begin
        // mask is already zero here; flush keeps it so and leaves the snapshot alone.
        if (bus.flush) begin
          mask_d = '0;
        end else begin
          mask_d = mask_q;
        end
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ACCUM;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = ACCUM;
        mask_d      = '0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      mask_q      <= '0;
      out_mask_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      out_mask_q  <= out_mask_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.mask      = mask_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_mask  = out_mask_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_pdecoder_acc.sv
module tb_pdecoder_acc;
  import pdecoder_acc_pkg::*;

  localparam int W = 127;

  typedef logic [W-1:0] vec_w;

  typedef struct {
    bit   v;
    int   idx;
    bit   set;
    bit   last;
    bit   flush;
    bit   ordy;
    vec_w e_mask;
    bit   e_ov;
    vec_w e_omask;   // compared only when e_ov is 1
    bit   e_err;
    bit   e_rdy;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  pdecoder_acc_if #(.WIDTH(W)) bus ();

  pdecoder_acc #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic vec_w oh(input int i);
    vec_w r;
    r = '0;
    if (i >= 0 && i < W) r[i] = 1'b1;
    return r;
  endfunction

  // Reference priority encoder: lowest set bit, -1 if none.
  function automatic int penc(input vec_w m);
    int p;
    p = -1;
    for (int i = W - 1; i >= 0; i--) if (m[i]) p = i;
    return p;
  endfunction

  function automatic vec_t mk(input bit v, input int idx, input bit set, input bit last,
                              input bit flush, input bit ordy, input vec_w e_mask,
                              input bit e_ov, input vec_w e_omask, input bit e_err,
                              input bit e_rdy);
    vec_t t;
    t.v = v; t.idx = idx; t.set = set; t.last = last; t.flush = flush; t.ordy = ordy;
    t.e_mask = e_mask; t.e_ov = e_ov; t.e_omask = e_omask; t.e_err = e_err; t.e_rdy = e_rdy;
    return t;
  endfunction

  task automatic chk(input string nm, input vec_w act, input vec_w exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit v, input int idx, input bit set, input bit last,
                       input bit flush, input bit ordy);
    bus.in_valid  = v;
    bus.in_idx    = 7'(idx);
    bus.in_set    = set;
    bus.in_last   = last;
    bus.flush     = flush;
    bus.out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];

  initial begin
    vec_w snap;

    drive(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset held for two cycles.
    rst = 1'b1;
    tick(); tick();
    chk("reset_mask", bus.mask, '0);
    chk("reset_out_valid", vec_w'(bus.out_valid), '0);
    chk("reset_err", vec_w'(bus.err), '0);
    rst = 1'b0;
    #1;
    chk("reset_in_ready", vec_w'(bus.in_ready), vec_w'(1));

    // Cycle-by-cycle vectors: inputs applied for one edge, results checked after it.
    tbl.push_back(mk(1, 0,   1, 0, 0, 0, oh(0),        0, '0, 0, 1));
    tbl.push_back(mk(1, 5,   1, 0, 0, 0, oh(0)|oh(5),  0, '0, 0, 1));
    tbl.push_back(mk(1, 126, 1, 1, 0, 0, '0, 1, oh(0)|oh(5)|oh(126), 0, 0));
    tbl.push_back(mk(0, 0,   0, 0, 0, 1, '0,           0, '0, 0, 1));
    tbl.push_back(mk(1, 5,   1, 0, 0, 0, oh(5),        0, '0, 0, 1));
    tbl.push_back(mk(1, 5,   0, 0, 0, 0, '0,           0, '0, 0, 1));
    tbl.push_back(mk(1, 3,   1, 1, 0, 0, '0,           1, vec_w'(8), 0, 0));
    tbl.push_back(mk(0, 0,   0, 0, 0, 1, '0,           0, '0, 0, 1));
    tbl.push_back(mk(1, 7,   1, 0, 0, 0, oh(7),        0, '0, 0, 1));
    tbl.push_back(mk(1, 8,   1, 0, 1, 0, '0,           0, '0, 0, 0));
    tbl.push_back(mk(1, 8,   1, 0, 0, 0, oh(8),        0, '0, 0, 1));
    tbl.push_back(mk(1, 8,   0, 1, 0, 0, '0,           1, '0, 0, 0));
    tbl.push_back(mk(0, 0,   0, 0, 0, 1, '0,           0, '0, 0, 1));
    tbl.push_back(mk(1, 127, 1, 1, 0, 0, '0,           1, '0, 1, 0));
    tbl.push_back(mk(0, 0,   0, 0, 0, 1, '0,           0, '0, 1, 1));
    tbl.push_back(mk(1, 2,   1, 1, 0, 0, '0,           1, oh(2), 1, 0));
    tbl.push_back(mk(0, 0,   0, 0, 0, 1, '0,           0, '0, 1, 1));
    tbl.push_back(mk(1, 4,   1, 1, 0, 0, '0,           1, oh(4), 1, 0));
    tbl.push_back(mk(1, 6,   1, 0, 0, 1, '0,           0, '0, 1, 1));
    tbl.push_back(mk(1, 6,   1, 0, 0, 0, oh(6),        0, '0, 1, 1));
    tbl.push_back(mk(0, 0,   0, 0, 1, 0, '0,           0, '0, 1, 0));

    foreach (tbl[k]) begin
      drive(tbl[k].v, tbl[k].idx, tbl[k].set, tbl[k].last, tbl[k].flush, tbl[k].ordy);
      tick();
      chk($sformatf("vec%0d_mask", k), bus.mask, tbl[k].e_mask);
      chk($sformatf("vec%0d_out_valid", k), vec_w'(bus.out_valid), vec_w'(tbl[k].e_ov));
      if (tbl[k].e_ov) chk($sformatf("vec%0d_out_mask", k), bus.out_mask, tbl[k].e_omask);
      chk($sformatf("vec%0d_err", k), vec_w'(bus.err), vec_w'(tbl[k].e_err));
      chk($sformatf("vec%0d_in_ready", k), vec_w'(bus.in_ready), vec_w'(tbl[k].e_rdy));
    end

    // Back-pressure: snapshot held 4 cycles (one with flush) while a beat waits.
    drive(1'b1, 10, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk("bp_first_out_valid", vec_w'(bus.out_valid), vec_w'(1));
    snap = oh(10);
    drive(1'b1, 11, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      bus.flush = (k == 2);
      tick();
      chk($sformatf("bp%0d_out_valid", k), vec_w'(bus.out_valid), vec_w'(1));
      chk($sformatf("bp%0d_out_mask", k), bus.out_mask, snap);
      chk($sformatf("bp%0d_in_ready", k), vec_w'(bus.in_ready), '0);
      chk($sformatf("bp%0d_mask", k), bus.mask, '0);
    end
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("bp_hs_out_valid", vec_w'(bus.out_valid), '0);
    chk("bp_hs_mask_bubble", bus.mask, '0);
    chk("bp_hs_in_ready", vec_w'(bus.in_ready), vec_w'(1));
    bus.out_ready = 1'b0;
    tick();
    chk("bp_after_mask", bus.mask, oh(11));
    drive(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Mid-frame reset discards partial mask and clears sticky err.
    drive(1'b1, 9, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("pre_rst_mask", bus.mask, oh(11) | oh(9));
    drive(1'b1, 12, 1'b1, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    chk("rst_mask", bus.mask, '0);
    chk("rst_out_valid", vec_w'(bus.out_valid), '0);
    chk("rst_err", vec_w'(bus.err), '0);
    rst = 1'b0;
    drive(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    chk("post_rst_no_snapshot", vec_w'(bus.out_valid), '0);

    // Sweep every index as a single-beat frame, round-tripped through a priority encoder.
    for (int i = 0; i < W; i++) begin
      drive(1'b1, i, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      chk($sformatf("sweep%0d_out_valid", i), vec_w'(bus.out_valid), vec_w'(1));
      chk($sformatf("sweep%0d_out_mask", i), bus.out_mask, oh(i));
      chk($sformatf("sweep%0d_penc", i), vec_w'(penc(bus.out_mask)), vec_w'(i));
      drive(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      chk($sformatf("sweep%0d_release", i), vec_w'(bus.out_valid), '0);
    end
    chk("sweep_err", vec_w'(bus.err), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
